// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - two-port round-robin arbiter and sequencer for the data-memory port
// One transaction in flight at a time: grant in IDLE, strobe in ACCESS, wait out read latency, respond.
module dmem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              m0_req_valid_i,
    output logic              m0_req_ready_o,
    input  logic              m0_req_write_i,
    input  logic [ADDR_W-1:0] m0_req_addr_i,
    input  logic [DATA_W-1:0] m0_req_wdata_i,
    input  logic [3:0]        m0_req_mask_i,
    output logic              m0_rsp_valid_o,
    output logic [DATA_W-1:0] m0_rsp_rdata_o,
    input  logic              m1_req_valid_i,
    output logic              m1_req_ready_o,
    input  logic              m1_req_write_i,
    input  logic [ADDR_W-1:0] m1_req_addr_i,
    input  logic [DATA_W-1:0] m1_req_wdata_i,
    input  logic [3:0]        m1_req_mask_i,
    output logic              m1_rsp_valid_o,
    output logic [DATA_W-1:0] m1_rsp_rdata_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_memwrite_o,
    output logic              mem_memread_o,
    output logic [3:0]        mem_sign_mask_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    localparam logic [1:0] LP_WAIT_INIT = 2'(RD_LATENCY - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic              r_last_grant;
    logic              r_grant;
    logic              r_write;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [3:0]        r_mask;
    logic [1:0]        r_cnt;
    logic [DATA_W-1:0] r_rdata;
    logic              w_any_valid;
    logic              w_sel_port;
    logic              w_handshake;

    assign w_any_valid = m0_req_valid_i | m1_req_valid_i;
    // On a tie the port that did not win last time is chosen.
    assign w_sel_port  = (m0_req_valid_i & m1_req_valid_i) ? ~r_last_grant : m1_req_valid_i;
    assign w_handshake = (r_state == S_IDLE) & w_any_valid;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (w_handshake) w_next_state = S_ACCESS;
            S_ACCESS: w_next_state = r_write ? S_RESP : S_WAIT;
            S_WAIT:   if (r_cnt == 2'd0) w_next_state = S_RESP;
            S_RESP:   w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        m0_req_ready_o = 1'b0;
        m1_req_ready_o = 1'b0;
        m0_rsp_valid_o = 1'b0;
        m1_rsp_valid_o = 1'b0;
        mem_memwrite_o = 1'b0;
        mem_memread_o  = 1'b0;
        busy_o         = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                m0_req_ready_o = w_any_valid & ~w_sel_port;
                m1_req_ready_o = w_any_valid & w_sel_port;
            end
            S_ACCESS: begin
                mem_memwrite_o = r_write;
                mem_memread_o  = ~r_write;
            end
            S_RESP: begin
                m0_rsp_valid_o = ~r_grant;
                m1_rsp_valid_o = r_grant;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_last_grant <= 1'b1;
            r_grant      <= 1'b0;
            r_write      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_mask       <= '0;
            r_cnt        <= '0;
            r_rdata      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_handshake) begin
                        r_grant      <= w_sel_port;
                        r_last_grant <= w_sel_port;
                        r_write      <= w_sel_port ? m1_req_write_i : m0_req_write_i;
                        r_addr       <= w_sel_port ? m1_req_addr_i  : m0_req_addr_i;
                        r_wdata      <= w_sel_port ? m1_req_wdata_i : m0_req_wdata_i;
                        r_mask       <= w_sel_port ? m1_req_mask_i  : m0_req_mask_i;
                    end
                end
                S_ACCESS: begin
                    if (r_write) begin
                        r_rdata <= '0;
                    end else begin
                        r_cnt <= LP_WAIT_INIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 2'd0) begin
                        r_rdata <= mem_rdata_i;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_addr_o      = r_addr;
    assign mem_wdata_o     = r_wdata;
    assign mem_sign_mask_o = r_mask;
    assign m0_rsp_rdata_o  = r_rdata;
    assign m1_rsp_rdata_o  = r_rdata;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - self-checking bench for dmem_port_arbiter
// A transaction-level model checks the latency-1 instance every cycle; a latency-4 instance gets directed checks.
module tb_dmem_port_arbiter;

    localparam int LA = 1;
    localparam int LB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        m0v, m0w, m1v, m1w, m0r, m1r, m0rv, m1rv;
    logic [31:0] m0a, m0d, m1a, m1d, m0rd, m1rd;
    logic [3:0]  m0k, m1k, mmask;
    logic [31:0] maddr, mwdata, mrdata;
    logic        mwr, mrd, busy;

    logic        b_rst;
    logic        b_m0v, b_m0w, b_m1v, b_m1w, b_m0r, b_m1r, b_m0rv, b_m1rv;
    logic [31:0] b_m0a, b_m0d, b_m1a, b_m1d, b_m0rd, b_m1rd;
    logic [3:0]  b_m0k, b_m1k, b_mmask;
    logic [31:0] b_maddr, b_mwdata, b_mem;
    logic        b_mwr, b_mrd, b_busy;

    int vec   = 0;
    int fails = 0;

    dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(LA)) u_dut (
        .clk_i(clk), .reset_i(rst),
        .m0_req_valid_i(m0v), .m0_req_ready_o(m0r), .m0_req_write_i(m0w),
        .m0_req_addr_i(m0a), .m0_req_wdata_i(m0d), .m0_req_mask_i(m0k),
        .m0_rsp_valid_o(m0rv), .m0_rsp_rdata_o(m0rd),
        .m1_req_valid_i(m1v), .m1_req_ready_o(m1r), .m1_req_write_i(m1w),
        .m1_req_addr_i(m1a), .m1_req_wdata_i(m1d), .m1_req_mask_i(m1k),
        .m1_rsp_valid_o(m1rv), .m1_rsp_rdata_o(m1rd),
        .mem_addr_o(maddr), .mem_wdata_o(mwdata), .mem_memwrite_o(mwr),
        .mem_memread_o(mrd), .mem_sign_mask_o(mmask), .mem_rdata_i(mrdata),
        .busy_o(busy)
    );

    dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(LB)) u_dut_lat4 (
        .clk_i(clk), .reset_i(b_rst),
        .m0_req_valid_i(b_m0v), .m0_req_ready_o(b_m0r), .m0_req_write_i(b_m0w),
        .m0_req_addr_i(b_m0a), .m0_req_wdata_i(b_m0d), .m0_req_mask_i(b_m0k),
        .m0_rsp_valid_o(b_m0rv), .m0_rsp_rdata_o(b_m0rd),
        .m1_req_valid_i(b_m1v), .m1_req_ready_o(b_m1r), .m1_req_write_i(b_m1w),
        .m1_req_addr_i(b_m1a), .m1_req_wdata_i(b_m1d), .m1_req_mask_i(b_m1k),
        .m1_rsp_valid_o(b_m1rv), .m1_rsp_rdata_o(b_m1rd),
        .mem_addr_o(b_maddr), .mem_wdata_o(b_mwdata), .mem_memwrite_o(b_mwr),
        .mem_memread_o(b_mrd), .mem_sign_mask_o(b_mmask), .mem_rdata_i(b_mem),
        .busy_o(b_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory read data: a per-cycle changing pattern unless a fixed value is forced.
    logic        mem_hold = 1'b0;
    logic [31:0] mem_hold_val = 32'h0;
    int          tb_cyc = 0;
    initial begin
        mrdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            tb_cyc++;
            mrdata = mem_hold ? mem_hold_val : {16'hC0DE, tb_cyc[15:0]};
        end
    end

    // Transaction-level model: one slot, schedule derived from the handshake cycle.
    int          m_cyc  = 0;
    bit          m_on   = 1'b0;
    bit          m_act  = 1'b0;
    bit          m_last = 1'b1;
    bit          m_wr   = 1'b0;
    bit          m_port = 1'b0;
    int          m_t    = 0;
    int          m_resp = 0;
    logic [31:0] e_addr = '0, e_wdata = '0, e_rdata = '0;
    logic [3:0]  e_mask = '0;

    always @(negedge clk) begin
        logic m_sel, m_any, m_idle;
        m_cyc++;
        if (m_act && m_cyc > m_resp) m_act = 1'b0;
        m_idle = !m_act;
        m_any  = m0v | m1v;
        m_sel  = (m0v && m1v) ? !m_last : m1v;
        if (m_on) begin
            chk("mdl_m0_ready", 32'(m0r), 32'(m_idle && m_any && !m_sel));
            chk("mdl_m1_ready", 32'(m1r), 32'(m_idle && m_any && m_sel));
            chk("mdl_memread", 32'(mrd), 32'(m_act && m_cyc == m_t + 1 && !m_wr));
            chk("mdl_memwrite", 32'(mwr), 32'(m_act && m_cyc == m_t + 1 && m_wr));
            chk("mdl_m0_rsp_valid", 32'(m0rv), 32'(m_act && m_cyc == m_resp && !m_port));
            chk("mdl_m1_rsp_valid", 32'(m1rv), 32'(m_act && m_cyc == m_resp && m_port));
            chk("mdl_busy", 32'(busy), 32'(m_act));
            chk("mdl_mem_addr", maddr, e_addr);
            chk("mdl_mem_wdata", mwdata, e_wdata);
            chk("mdl_mem_mask", 32'(mmask), 32'(e_mask));
            chk("mdl_m0_rdata", m0rd, e_rdata);
            chk("mdl_m1_rdata", m1rd, e_rdata);
        end
        if (rst) begin
            m_on = 1'b1; m_act = 1'b0; m_last = 1'b1;
            e_addr = '0; e_wdata = '0; e_mask = '0; e_rdata = '0;
        end else if (m_on) begin
            if (m_act && m_cyc == m_resp - 1) e_rdata = m_wr ? 32'h0 : mrdata;
            if (m_idle && m_any) begin
                m_act   = 1'b1;
                m_t     = m_cyc;
                m_port  = m_sel;
                m_last  = m_sel;
                m_wr    = m_sel ? m1w : m0w;
                e_addr  = m_sel ? m1a : m0a;
                e_wdata = m_sel ? m1d : m0d;
                e_mask  = m_sel ? m1k : m0k;
                m_resp  = m_cyc + (m_wr ? 2 : 2 + LA);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int gp[$];
        int gc[$];
        int n0, n1, cnt;
        rst = 1'b1; b_rst = 1'b1;
        m0v = 0; m0w = 0; m0a = 0; m0d = 0; m0k = 0;
        m1v = 0; m1w = 0; m1a = 0; m1d = 0; m1k = 0;
        b_m0v = 0; b_m0w = 0; b_m0a = 0; b_m0d = 0; b_m0k = 0;
        b_m1v = 0; b_m1w = 0; b_m1a = 0; b_m1d = 0; b_m1k = 0;
        b_mem = 32'h0;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_ready", {m0r, m1r}, 0);
        chk("rst_rsp_valid", {m0rv, m1rv}, 0);
        chk("rst_strobes", {mrd, mwr}, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_addr", maddr, 0);
        chk("rst_wdata_mask", mwdata | 32'(mmask), 0);
        chk("rst_rdata", m0rd, 0);
        chk("rst_b_busy", 32'(b_busy), 0);
        tick();
        rst = 1'b0; b_rst = 1'b0;
        tick();

        // m0 read, latency 1
        mem_hold = 1'b1; mem_hold_val = 32'hDEADBEEF;
        m0v = 1; m0w = 0; m0a = 32'h100; m0k = 4'b1111;
        @(negedge clk); chk("t1_ready_T", 32'(m0r), 1);
        tick(); m0v = 0;
        @(negedge clk); chk("t1_read_T1", 32'(mrd), 1); chk("t1_addr_T1", maddr, 32'h100);
        tick();
        @(negedge clk); chk("t1_read_T2", 32'(mrd), 0); chk("t1_rsp_T2", 32'(m0rv), 0);
        tick();
        @(negedge clk); chk("t1_rsp_T3", 32'(m0rv), 1); chk("t1_rdata_T3", m0rd, 32'hDEADBEEF);
        chk("t1_m1_rsp_T3", 32'(m1rv), 0);
        tick();
        @(negedge clk); chk("t1_rsp_T4", 32'(m0rv), 0); chk("t1_busy_T4", 32'(busy), 0);
        mem_hold = 1'b0;

        // m1 write
        tick();
        m1v = 1; m1w = 1; m1a = 32'h20; m1d = 32'h12345678; m1k = 4'b0010;
        @(negedge clk); chk("t2_ready_T", 32'(m1r), 1); chk("t2_busy_T", 32'(busy), 0);
        tick(); m1v = 0;
        @(negedge clk);
        chk("t2_write_T1", 32'(mwr), 1); chk("t2_addr_T1", maddr, 32'h20);
        chk("t2_wdata_T1", mwdata, 32'h12345678); chk("t2_mask_T1", 32'(mmask), 32'h2);
        chk("t2_busy_T1", 32'(busy), 1);
        tick();
        @(negedge clk); chk("t2_rsp_T2", 32'(m1rv), 1); chk("t2_rdata_T2", m1rd, 0);
        chk("t2_busy_T2", 32'(busy), 1);
        tick();
        @(negedge clk); chk("t2_busy_T3", 32'(busy), 0);

        // both ports reading continuously
        tick();
        m0v = 1; m0w = 0; m0a = 32'h200; m1v = 1; m1w = 0; m1a = 32'h300;
        n0 = 0; n1 = 0;
        for (int c = 0; c < 40 && gp.size() < 4; c++) begin
            @(negedge clk);
            if (m0r && m0v) begin gp.push_back(0); gc.push_back(c); end
            if (m1r && m1v) begin gp.push_back(1); gc.push_back(c); end
            if (m0rv) n0++;
            if (m1rv) n1++;
            tick();
        end
        m0v = 0; m1v = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (m0rv) n0++;
            if (m1rv) n1++;
            tick();
        end
        chk("t3_grant_count", gp.size(), 4);
        if (gp.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("t3_grant_order", gp[i], i % 2);
            for (int i = 1; i < 4; i++) chk("t3_spacing", gc[i] - gc[i-1], 3 + LA);
        end
        chk("t3_m0_rsp_count", n0, 2);
        chk("t3_m1_rsp_count", n1, 2);

        // reset during WAIT of an m1 read
        m1v = 1; m1w = 0; m1a = 32'h44;
        @(negedge clk); chk("t5_ready_T", 32'(m1r), 1);
        tick(); m1v = 0;
        @(negedge clk); chk("t5_read_T1", 32'(mrd), 1);
        tick(); rst = 1'b1;
        @(negedge clk); chk("t5_busy_wait", 32'(busy), 1);
        tick(); rst = 1'b0;
        @(negedge clk);
        chk("t5_busy_after", 32'(busy), 0);
        chk("t5_strobes_after", {mrd, mwr}, 0);
        cnt = 32'(m1rv);
        for (int c = 0; c < 5; c++) begin
            tick();
            @(negedge clk);
            if (m1rv) cnt++;
        end
        chk("t5_no_m1_rsp", cnt, 0);
        tick();
        m0v = 1; m0w = 0; m0a = 32'h500; m1v = 1; m1w = 0; m1a = 32'h600;
        @(negedge clk); chk("t5_tie_m0", {m0r, m1r}, 2'b10);
        tick(); m0v = 0; m1v = 0;
        for (int c = 0; c < 10 && busy; c++) tick();
        @(negedge clk); chk("t5_idle", 32'(busy), 0);

        // m0 valid pulse during ACCESS is ignored
        tick();
        m0v = 1; m0w = 1; m0a = 32'h80; m0d = 32'hCAFEF00D; m0k = 4'b1111;
        @(negedge clk); chk("t6_ready_T", 32'(m0r), 1);
        tick(); m0a = 32'h84;
        @(negedge clk); chk("t6_no_ready_access", 32'(m0r), 0);
        chk("t6_write_T1", 32'(mwr), 1); chk("t6_addr_T1", maddr, 32'h80);
        tick(); m0v = 0;
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (mrd || mwr) cnt++;
            tick();
        end
        chk("t6_no_extra_strobe", cnt, 0);
        m0v = 1; m1v = 1; m0w = 1; m1w = 1; m1a = 32'h90;
        @(negedge clk); chk("t6_tie_m1", {m0r, m1r}, 2'b01);
        tick(); m0v = 0; m1v = 0;
        for (int c = 0; c < 10 && busy; c++) tick();

        // latency-4 instance
        tick();
        b_m0v = 1; b_m0w = 0; b_m0a = 32'h300; b_m0k = 4'b1111; b_mem = 32'h40000000;
        @(negedge clk); chk("t4_ready_T", 32'(b_m0r), 1);
        for (int k = 1; k <= 7; k++) begin
            tick();
            b_m0v = 0;
            b_mem = 32'h40000000 + 32'(k);
            @(negedge clk);
            chk("t4_memread", 32'(b_mrd), 32'(k == 1));
            chk("t4_rsp_valid", 32'(b_m0rv), 32'(k == 6));
            chk("t4_busy", 32'(b_busy), 32'(k <= 6));
            if (k == 1) chk("t4_addr", b_maddr, 32'h300);
            if (k == 6) chk("t4_rdata", b_m0rd, 32'h40000005);
        end
        chk("t4_m1_rsp", 32'(b_m1rv), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, fails);
        $finish;
    end

endmodule
